instruction_loader: RTL

//  Write-side counterpart of the instruction memory: receives a program as a

---
 rtl/instruction_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/instruction_loader.sv
// Byte-stream program loader: assembles big-endian words and writes them into instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum word after the last write.
module instruction_loader #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 181,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // state | meaning
    // IDLE  | nothing loaded since reset, waiting for start
    // RECV  | collecting the four bytes of the current word
    // WRITE | one-cycle memory write of the assembled word
    // CHK   | collecting the four checksum bytes (checksum build only)
    // DONE  | load finished or rejected; done/error hold until next start
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHK, S_DONE} state_t;

    localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(DEPTH - BASE_ADDR);

    state_t            state;
    logic [31:0]       sr;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] count;
    logic              take;
    logic [31:0]       sr_next;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       xor_acc;
`endif

    assign take     = byte_valid && byte_ready;
    assign sr_next  = {sr[23:0], byte_in};
    assign cpu_hold = busy;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            sr         <= '0;
            byte_cnt   <= '0;
            word_idx   <= '0;
            count      <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_acc    <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (take) begin
                sr       <= sr_next;
                byte_cnt <= byte_cnt + 2'd1;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            error <= 1'b0;
                        end else if ({1'b0, word_count} > MAX_WORDS) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            state      <= S_RECV;
                            count      <= word_count;
                            word_idx   <= '0;
                            byte_cnt   <= '0;
                            done       <= 1'b0;
                            error      <= 1'b0;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                            xor_acc    <= '0;
`endif
                        end
                    end
                end
                S_RECV: begin
                    if (take && byte_cnt == 2'd3) begin
                        state      <= S_WRITE;
                        byte_ready <= 1'b0;
                        mem_we     <= 1'b1;
                        mem_addr   <= ADDR_W'(BASE_ADDR) + word_idx;
                        mem_wdata  <= sr_next;
                    end
                end
                S_WRITE: begin
                    mem_addr  <= '0;
                    mem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
                    xor_acc   <= xor_acc ^ mem_wdata;
`endif
                    if (word_idx == count - ADDR_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                        state      <= S_CHK;
                        byte_ready <= 1'b1;
`else
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
`endif
                    end else begin
                        word_idx   <= word_idx + ADDR_W'(1);
                        state      <= S_RECV;
                        byte_ready <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (take && byte_cnt == 2'd3) begin
                        state      <= S_DONE;
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        error      <= (sr_next != xor_acc);
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
